// File: rtl/ssd_pkg.sv
// Shared constants, FSM encodings and segment decoding for the
// multiplexed seven-segment scan controller.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    // Active-low {a,b,c,d,e,f,g}; A..F rendered as A, b, C, d, E, F.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: BIN_WIDTH shift cycles then one
// commit cycle; o_done marks the cycle in which o_bcd/o_ovf are final.
module bin2bcd_seq #(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 8
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      i_start,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [4*NUM_DIGITS-1:0]   o_bcd,
    output logic                      o_ovf
);
    import ssd_pkg::*;

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    logic [1:0]           r_state;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [DISP_W-1:0]    r_bcd;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_cnt;
    logic [DISP_W-1:0]    w_adj;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin   <= i_bin;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    // A 1 leaving the top nibble means the value needs more digits.
                    r_bcd <= {w_adj[DISP_W-2:0], r_bin[BIN_WIDTH-1]};
                    r_ovf <= r_ovf | w_adj[DISP_W-1];
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT)
                        r_state <= ST_COMMIT;
                end
                ST_COMMIT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_COMMIT);
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment controller with hex/decimal modes,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int BIN_WIDTH     = 16,
    parameter int SCAN_DIV_BITS = 18
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [BIN_WIDTH-1:0]  Value,
    input  logic                  Load,
    input  logic                  Hex_mode,
    input  logic [NUM_DIGITS-1:0] Dp_mask,
    input  logic                  Blank_lz,
    input  logic                  Enable,
    output logic                  Busy,
    output logic                  Overflow,
    output logic [NUM_DIGITS-1:0] An,
    output logic [7:0]            Cathodes
);
    import ssd_pkg::*;

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CAP_W  = (BIN_WIDTH < DISP_W) ? BIN_WIDTH : DISP_W;

    logic                     w_busy, w_done, w_conv_ovf, w_start, w_hex_load, w_hex_ovf;
    logic [DISP_W-1:0]        w_bcd, w_hex_disp;
    logic [DISP_W-1:0]        r_disp;
    logic                     r_ovf;
    logic [SCAN_DIV_BITS-1:0] r_presc;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_DIGITS-1:0]    r_an;
    logic [7:0]               r_cath;
    logic [3:0]               w_nib;
    logic [NUM_DIGITS-1:0]    w_blank, w_an;
    logic                     w_zero_run;
    logic [6:0]               w_seg;

    // Loads are only honoured in IDLE; a request during conversion is dropped.
    assign w_start    = Load && !Hex_mode && !w_busy;
    assign w_hex_load = Load &&  Hex_mode && !w_busy;

    bin2bcd_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_start (w_start),
        .i_bin   (Value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_conv_ovf)
    );

    always_comb begin
        w_hex_disp = '0;
        w_hex_disp[CAP_W-1:0] = Value[CAP_W-1:0];
    end

    generate
        if (BIN_WIDTH > DISP_W) begin : g_hex_ovf
            assign w_hex_ovf = |Value[BIN_WIDTH-1:DISP_W];
        end else begin : g_no_hex_ovf
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_hex_load) begin
            r_disp <= w_hex_disp;
            r_ovf  <= w_hex_ovf;
        end else if (w_done) begin
            r_disp <= w_bcd;
            r_ovf  <= w_conv_ovf;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (&r_presc)
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        w_nib      = '0;
        w_an       = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_disp[4*i +: 4] == 4'd0);
            w_blank[i] = (i > 0) && w_zero_run;
            if (r_idx == IDX_W'(i))
                w_nib = r_disp[4*i +: 4];
        end
        w_an[r_idx] = 1'b0;
        if (r_ovf)
            w_seg = SEG_DASH;
        else if (Blank_lz && w_blank[r_idx])
            w_seg = SEG_BLANK;
        else
            w_seg = hex_to_seg(w_nib);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an   <= '1;
            r_cath <= 8'hFF;
        end else begin
            r_an   <= Enable ? w_an : '1;
            r_cath <= {w_seg, ~Dp_mask[r_idx]};
        end
    end

    assign Busy     = w_busy;
    assign Overflow = r_ovf;
    assign An       = r_an;
    assign Cathodes = r_cath;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with 4 digits and a 4-clock digit period.
module tb_ssd_scan_ctrl;

    localparam int ND = 4;
    localparam int BW = 16;
    localparam int SD = 2;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [BW-1:0] Value;
    logic          Load;
    logic          Hex_mode;
    logic [ND-1:0] Dp_mask;
    logic          Blank_lz;
    logic          Enable;
    logic          Busy;
    logic          Overflow;
    logic [ND-1:0] An;
    logic [7:0]    Cathodes;

    typedef struct {
        int         digit;
        logic [7:0] cath;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cur_val  = 0;
    bit   cur_hex  = 1'b1;

    ssd_scan_ctrl #(
        .NUM_DIGITS    (ND),
        .BIN_WIDTH     (BW),
        .SCAN_DIV_BITS (SD)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Value    (Value),
        .Load     (Load),
        .Hex_mode (Hex_mode),
        .Dp_mask  (Dp_mask),
        .Blank_lz (Blank_lz),
        .Enable   (Enable),
        .Busy     (Busy),
        .Overflow (Overflow),
        .An       (An),
        .Cathodes (Cathodes)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] seg_of(int n);
        case (n)
            0: return 7'b0000001;   1: return 7'b1001111;
            2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;
            6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [7:0] exp_cath(int val, bit hex, bit blank, logic [ND-1:0] dpm, int d);
        int base = 1;
        int nib, upper;
        bit ovf;
        logic [6:0] seg;
        if (hex) begin
            upper = val >> (4 * d);
            nib   = upper & 15;
            ovf   = (val >> (4 * ND)) != 0;
        end else begin
            for (int k = 0; k < d; k++) base = base * 10;
            upper = val / base;
            nib   = upper % 10;
            ovf   = val > 9999;
        end
        if (ovf)                          seg = 7'b1111110;
        else if (blank && d > 0 && upper == 0) seg = 7'b1111111;
        else                              seg = seg_of(nib);
        return {seg, ~dpm[d]};
    endfunction

    task automatic push_expect(int val, bit hex);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.digit = d;
            e.cath  = exp_cath(val, hex, Blank_lz, Dp_mask, d);
            exp_q.push_back(e);
        end
        cur_val = val;
        cur_hex = hex;
    endtask

    task automatic do_load(int val, bit hex);
        Value    = BW'(val);
        Hex_mode = hex;
        Load     = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    // Pops one full scan worth of expectations and checks every clock of it.
    task automatic scan_check(string name);
        logic [ND-1:0] prev = An;
        bit found = 1'b0;
        exp_t e;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge Clk);
            if (An === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            else prev = An;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL %s scan_sync: An=%b never started digit 0", name, An);
            repeat (ND) if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        for (int d = 0; d < ND; d++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL %s scoreboard: empty queue at digit %0d", name, d);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c < (1 << SD); c++) begin
                n_checks++;
                if ({An, Cathodes} !== {~(4'b0001 << e.digit), e.cath})
                    $display("FAIL %s digit%0d clk%0d: An/Cath got %b/%b expected %b/%b",
                             name, e.digit, c, An, Cathodes, ~(4'b0001 << e.digit), e.cath);
                else n_pass++;
                @(negedge Clk);
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Load = 1'b0; Value = '0; Hex_mode = 1'b1;
        Dp_mask = '0; Blank_lz = 1'b0; Enable = 1'b1;
        #12;
        n_checks++;
        if ({Busy, Overflow, An, Cathodes} !== {1'b0, 1'b0, 4'b1111, 8'hFF})
            $display("FAIL reset: busy/ovf/an/cath got %b/%b/%b/%h expected 0/0/1111/ff",
                     Busy, Overflow, An, Cathodes);
        else n_pass++;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_hex(string name, int val);
        bit busy_seen = 1'b0;
        do_load(val, 1'b1);
        push_expect(val, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (Busy !== 1'b0) busy_seen = 1'b1;
            @(negedge Clk);
        end
        n_checks++;
        if (busy_seen) $display("FAIL %s busy: got 1 expected 0 throughout", name);
        else n_pass++;
        n_checks++;
        if (Overflow !== 1'b0) $display("FAIL %s overflow: got %b expected 0", name, Overflow);
        else n_pass++;
        scan_check(name);
    endtask

    // Decimal load; optionally re-pulses Load at busy cycle glitch_at.
    task automatic test_decimal(string name, int val, int glitch_at);
        logic [7:0] old_cath [ND];
        int n = 0;
        for (int d = 0; d < ND; d++)
            old_cath[d] = exp_cath(cur_val, cur_hex, Blank_lz, Dp_mask, d);
        do_load(val, 1'b0);
        push_expect(val, 1'b0);
        while (Busy === 1'b1 && n < 100) begin
            Load = (n == glitch_at);
            if (n == glitch_at) Value = 16'd9876;
            for (int d = 0; d < ND; d++) begin
                if (An === ~(4'b0001 << d)) begin
                    n_checks++;
                    if (Cathodes !== old_cath[d])
                        $display("FAIL %s hold digit%0d busy%0d: got %b expected %b",
                                 name, d, n, Cathodes, old_cath[d]);
                    else n_pass++;
                end
            end
            n++;
            @(negedge Clk);
        end
        Load = 1'b0;
        n_checks++;
        if (n != BW + 1) $display("FAIL %s busy_len: got %0d expected %0d", name, n, BW + 1);
        else n_pass++;
        n_checks++;
        if (Overflow !== (val > 9999))
            $display("FAIL %s overflow: got %b expected %b", name, Overflow, val > 9999);
        else n_pass++;
        scan_check(name);
    endtask

    task automatic test_reset_mid_conv();
        Blank_lz = 1'b0; Dp_mask = '0;
        do_load(1234, 1'b0);
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Overflow, An, Cathodes} !== {1'b0, 1'b0, 4'b1111, 8'hFF})
            $display("FAIL reset_mid: busy/ovf/an/cath got %b/%b/%b/%h expected 0/0/1111/ff",
                     Busy, Overflow, An, Cathodes);
        else n_pass++;
        @(negedge Clk);
        Reset_n = 1'b1;
        push_expect(0, 1'b1);
        scan_check("reset_mid_display");
        n_checks++;
        if (Busy !== 1'b0) $display("FAIL reset_mid busy_after: got %b expected 0", Busy);
        else n_pass++;
    endtask

    task automatic test_enable();
        Enable = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (An !== 4'b1111) $display("FAIL enable_off cyc%0d: An got %b expected 1111", i, An);
            else n_pass++;
            @(negedge Clk);
        end
        Enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hex("hex_00A5", 16'h00A5);
        test_decimal("dec_1234", 1234, -1);
        Blank_lz = 1'b1; Dp_mask = 4'b0010;
        test_decimal("dec_7_blank", 7, -1);
        Blank_lz = 1'b0; Dp_mask = '0;
        test_decimal("dec_1234_ignored_load", 1234, 4);
        test_decimal("dec_65535_overflow", 65535, -1);
        test_hex("hex_1234_clears_ovf", 16'h1234);
        test_reset_mid_conv();
        test_enable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
